// File: rtl/simon_data_out_if.sv
// Bundle of signals between the SIMON result path and the host-side packet port.
// The master modport is the packetiser's view; the slave modport is the environment's view.
interface simon_data_out_if #(
  parameter int N = 32
);
  logic                  newRESULT;
  logic [1:0][N-1:0]     outDATA;
  logic [7:0]            infoRES;
  logic                  loadRESULT;
  logic [(1+N/2):0][7:0] out;
  logic                  out_newPKT;
  logic                  out_loadPKT;
  logic [7:0]            countOUT;
  logic                  err;

  modport master (
    input  newRESULT, outDATA, infoRES, out_loadPKT,
    output loadRESULT, out, out_newPKT, countOUT, err
  );

  modport slave (
    output newRESULT, outDATA, infoRES, out_loadPKT,
    input  loadRESULT, out, out_newPKT, countOUT, err
  );
endinterface

// File: rtl/simon_data_out.sv
// SIMON 64/96 output packetiser: packs one or two finished cipher blocks into an
// outbound packet (4 words, count byte, info byte) offered with a valid/acknowledge handshake.
module simon_data_out #(
  parameter int          N    = 32,
  parameter logic [3:0]  MODE = 4'h2
) (
  input  logic            clk,
  input  logic            nR,
  simon_data_out_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    PACK  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0][N-1:0]     slot_q, slot_d;
  logic [7:0]            info_q, info_d;
  logic [(1+N/2):0][7:0] out_q, out_d;
  logic                  newpkt_q, newpkt_d;
  logic                  load_q, load_d;
  logic                  err_q, err_d;
  logic [7:0]            count_q, count_d;
  logic                  capture_s;

  // Next-state and datapath updates for the packetiser FSM.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    info_d   = info_q;
    out_d    = out_q;
    newpkt_d = newpkt_q;
    load_d   = 1'b0;
    err_d    = err_q;
    count_d  = count_q;

    capture_s = bus.newRESULT && !load_q;

    case (state_q)
      IDLE: begin
        // The FSM advances on the cycle after a capture, while loadRESULT is high.
        if (load_q) begin
          state_d = info_q[7] ? WAIT2 : PACK;
        end else if (capture_s) begin
          slot_d[0] = bus.outDATA[0];
          slot_d[1] = bus.outDATA[1];
          slot_d[2] = {N{1'b0}};
          slot_d[3] = {N{1'b0}};
          info_d    = {bus.infoRES[7], bus.infoRES[6], 1'b0, 1'b1, MODE};
          load_d    = 1'b1;
          err_d     = err_q | bus.infoRES[5];
        end else begin
          state_d = IDLE;
        end
      end
      WAIT2: begin
        if (load_q) begin
          state_d = PACK;
        end else if (capture_s) begin
          slot_d[2] = bus.outDATA[0];
          slot_d[3] = bus.outDATA[1];
          load_d    = 1'b1;
          err_d     = err_q | bus.infoRES[5];
        end else begin
          state_d = WAIT2;
        end
      end
      PACK: begin
        out_d    = {info_q, count_q, slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
        newpkt_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (bus.out_loadPKT) begin
          newpkt_d = 1'b0;
          count_d  = count_q + 8'd1;
          state_d  = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      info_q   <= 8'h00;
      out_q    <= '0;
      newpkt_q <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      info_q   <= info_d;
      out_q    <= out_d;
      newpkt_q <= newpkt_d;
      load_q   <= load_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign bus.loadRESULT = load_q;
  assign bus.out        = out_q;
  assign bus.out_newPKT = newpkt_q;
  assign bus.countOUT   = count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed testbench for simon_data_out: expected packets are queued at stimulus time
// and a separate monitor compares each packet as out_newPKT rises.
module tb_simon_data_out;
  localparam int N = 32;
  typedef logic [143:0] pkt_t;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  simon_data_out_if #(.N(N)) bus();

  simon_data_out #(.N(N), .MODE(4'h2)) dut (
    .clk (clk),
    .nR  (nR),
    .bus (bus.master)
  );

  pkt_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] push_cnt = 8'h00;
  logic [7:0] ack_cnt  = 8'h00;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [7:0] cnt, input logic [7:0] info);
    return {info, cnt, w3, w2, w1, w0};
  endfunction

  task automatic push(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3, input logic [7:0] info);
    sb_q.push_back(mk(w0, w1, w2, w3, push_cnt, info));
    push_cnt = push_cnt + 8'd1;
  endtask

  // Scoreboard monitor: one comparison per packet offered.
  initial begin
    logic prev;
    pkt_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (nR && bus.out_newPKT && !prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pkt", 144'd1, 144'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_packet", bus.out, e);
        end
      end
      prev = bus.out_newPKT;
    end
  end

  task automatic wait_load();
    int n;
    n = 0;
    while (bus.loadRESULT !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.loadRESULT !== 1'b1) check("load_timeout", 144'd0, 144'd1);
    bus.newRESULT = 1'b0;
    @(negedge clk);
    check("load_single_pulse", bus.loadRESULT, 144'd0);
  endtask

  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] info);
    @(posedge clk);
    #1;
    bus.newRESULT = 1'b1;
    bus.outDATA   = {w1, w0};
    bus.infoRES   = info;
    @(negedge clk);
    wait_load();
  endtask

  task automatic wait_pkt(output int n);
    n = 0;
    while (bus.out_newPKT !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_newPKT !== 1'b1) check("pkt_timeout", 144'd0, 144'd1);
  endtask

  task automatic ack();
    @(posedge clk);
    #1;
    bus.out_loadPKT = 1'b1;
    @(posedge clk);
    #1;
    bus.out_loadPKT = 1'b0;
    ack_cnt = ack_cnt + 8'd1;
    @(negedge clk);
    check("ack_newpkt_low", bus.out_newPKT, 144'd0);
    check("ack_count", bus.countOUT, ack_cnt);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nR = 1'b0;
    @(posedge clk);
    #1;
    nR = 1'b1;
    push_cnt = 8'h00;
    ack_cnt  = 8'h00;
    @(negedge clk);
    check("rst_out", bus.out, 144'd0);
    check("rst_newpkt", bus.out_newPKT, 144'd0);
    check("rst_load", bus.loadRESULT, 144'd0);
    check("rst_count", bus.countOUT, 144'd0);
    check("rst_err", bus.err, 144'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    pkt_t snap;
    bus.newRESULT   = 1'b0;
    bus.outDATA     = '0;
    bus.infoRES     = 8'h00;
    bus.out_loadPKT = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    // Acknowledge with no packet offered is ignored
    @(posedge clk); #1; bus.out_loadPKT = 1'b1;
    @(posedge clk); #1; bus.out_loadPKT = 1'b0;
    @(negedge clk);
    check("stray_ack_count", bus.countOUT, 144'd0);
    check("stray_ack_newpkt", bus.out_newPKT, 144'd0);

    // Single block packet
    push(32'hAABBCCDD, 32'h11223344, 32'h0, 32'h0, 8'h12);
    send_block(32'hAABBCCDD, 32'h11223344, 8'h00);
    wait_pkt(n);
    check("single_latency", n, 144'd1);
    check("single_info", bus.out[17], 144'h12);
    check("single_count_byte", bus.out[16], 144'h00);
    check("single_bytes_0_3", {bus.out[3], bus.out[2], bus.out[1], bus.out[0]}, 144'hAABBCCDD);
    ack();

    // Two block packet
    push(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 8'h92);
    send_block(32'h01020304, 32'h05060708, 8'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait2_no_pkt", bus.out_newPKT, 144'd0);
    end
    send_block(32'h090A0B0C, 32'h0D0E0F10, 8'h80);
    wait_pkt(n);
    check("two_block_latency", n, 144'd1);
    check("two_block_info", bus.out[17], 144'h92);
    ack();

    // Consumer stalls while a new block is waiting
    push(32'hCAFEF00D, 32'h12345678, 32'h0, 32'h0, 8'h12);
    send_block(32'hCAFEF00D, 32'h12345678, 8'h00);
    wait_pkt(n);
    snap = bus.out;
    push(32'h0BADBEEF, 32'hFEEDFACE, 32'h0, 32'h0, 8'h12);
    @(posedge clk); #1;
    bus.newRESULT = 1'b1;
    bus.outDATA   = {32'hFEEDFACE, 32'h0BADBEEF};
    bus.infoRES   = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_stable", bus.out, snap);
      check("stall_newpkt_high", bus.out_newPKT, 144'd1);
      check("stall_no_load", bus.loadRESULT, 144'd0);
    end
    ack();
    wait_load();
    wait_pkt(n);
    ack();

    // 257 packets from reset: count wraps
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push(i, ~i, 32'h0, 32'h0, 8'h12);
      send_block(i, ~i, 8'h00);
      wait_pkt(n);
      check("countout_seq", bus.countOUT, i % 256);
      ack();
    end
    check("wrap_err_low", bus.err, 144'd0);

    // Key packet on the result path sets sticky err
    push(32'h55AA55AA, 32'h33CC33CC, 32'h0, 32'h0, 8'h12);
    send_block(32'h55AA55AA, 32'h33CC33CC, 8'h20);
    check("err_set", bus.err, 144'd1);
    wait_pkt(n);
    check("err_info_bit5", bus.out[17], 144'h12);
    ack();
    repeat (3) @(negedge clk);
    check("err_sticky", bus.err, 144'd1);

    // Reset while waiting for the second block
    send_block(32'h44444444, 32'h66666666, 8'h80);
    do_reset();
    push(32'h77777777, 32'h88888888, 32'h0, 32'h0, 8'h12);
    send_block(32'h77777777, 32'h88888888, 8'h00);
    wait_pkt(n);
    check("post_rst_latency", n, 144'd1);
    ack();

    // Reset while offering a packet discards it
    push(32'h99999999, 32'hAAAAAAAA, 32'h0, 32'h0, 8'h12);
    send_block(32'h99999999, 32'hAAAAAAAA, 8'h00);
    wait_pkt(n);
    do_reset();
    repeat (3) @(negedge clk);
    check("discard_newpkt", bus.out_newPKT, 144'd0);

    check("sb_empty", sb_q.size(), 144'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_data_out.md
# simon_data_out

Output packetiser for the SIMON 64/96 datapath. Accepts finished cipher blocks (two N-bit words each) from the round core and packs one or two of them into an outbound packet with the same byte layout as the input packet: four data words, a count byte and an info byte. Presents the packet to the host-side interface with a level-valid / acknowledge handshake. Sits directly downstream of the core and mirrors the input packet loader on the return path.

## Interface
Parameters:
- N, 32, word width in bits; packet is 2+N/2 bytes (18 at default)
- MODE, 4'h2, cipher mode code written into info[3:0]

Ports:
- clk  in  1  system clock, all state on rising edge
- nR  in  1  reset; synchronous and active-low
- newRESULT  in  1  core holds a finished block on outDATA/infoRES; level, held until loadRESULT
- outDATA  in  [1:0][N-1:0]  finished block, word 0 and word 1
- infoRES  in  8  info byte that travelled with the block
- loadRESULT  out  1  one-cycle pulse: block captured, producer may drop newRESULT
- out  out  [(1+N/2):0][7:0]  outbound packet bytes
- out_newPKT  out  1  packet valid; level, held until out_loadPKT
- out_loadPKT  in  1  consumer has taken the packet
- countOUT  out  8  packet sequence count written into the next packet
- err  out  1  sticky: a block arrived with infoRES[5]=1 (key packet on result path)

## Operation
- Packet layout: byte groups [N/8-1:0] word 0, [N/4-1:N/8] word 1, [3N/8-1:N/4] word 2, [N/2-1:3N/8] word 3; byte N/2 = count; byte N/2+1 = info. Little-endian bytes within each word.
- Info byte out: {infoRES[7], infoRES[6], 1'b0, 1'b1, MODE}; bit4=1 marks output packet; bit5 forced 0.
- infoRES[7]=1 on the first block means a second block follows in the same packet.
- Capture condition: newRESULT && !loadRESULT (a block is never captured in the cycle loadRESULT is high).
- FSM states:
  - IDLE: on capture, first block's words go to 0/1 and words 2/3 clear to 0; info is latched, loadRESULT pulses, err sets if infoRES[5]. Next state is WAIT2 if infoRES[7] else PACK.
  - WAIT2: on capture, the block's words go to 2/3, loadRESULT pulses, err check as above; next PACK. The info byte is the one latched from the first block.
  - PACK: drive out from the slots, countOUT and the info byte; set out_newPKT; next SEND.
  - SEND: out and out_newPKT are held stable. On out_loadPKT, clear out_newPKT, increment countOUT, and go to IDLE. newRESULT is not captured in SEND.
- countOUT is 8-bit and wraps 255 to 0. It increments only on acknowledge.
- out_loadPKT while out_newPKT is low is ignored.
- Reset (nR low at a clock edge, any state):
  - state returns to IDLE
  - out, slots and latched info go to 0
  - out_newPKT, loadRESULT and err go to 0
  - countOUT goes to 0
  - a packet being offered is discarded

## Timing
- All outputs registered. Reset values are all 0.
- Single-block packet: newRESULT sampled high at edge t. loadRESULT is high t to t+1. out_newPKT is high from edge t+2.
- Two-block packet: out_newPKT rises 2 edges after the edge that captures the second block.
- Acknowledge: out_loadPKT sampled high at edge s. out_newPKT is low and countOUT increments after s. A new capture is possible from edge s+1.
- Minimum packet period with a consumer that acknowledges immediately is 4 cycles for a single block.
- The producer must drop newRESULT in the cycle after loadRESULT. Holding it longer causes a duplicate capture in WAIT2 or IDLE.

## Test plan
- Reset, then one block outDATA={32'h11223344, 32'hAABBCCDD}, infoRES=8'h00. Required:
  - loadRESULT is a single pulse
  - out_newPKT rises 2 cycles after capture
  - bytes 0..3 = DD,CC,BB,AA; bytes 4..7 = 44,33,22,11; bytes 8..15 = 0
  - count byte 00; info byte 8'h12
- Two-block packet: infoRES=8'h80 on both blocks. Words 2/3 hold the second block, info byte = 8'h92, and out_newPKT stays low while in WAIT2.
- Hold out_loadPKT low for 10 cycles. out is stable and out_newPKT high throughout, and newRESULT asserted meanwhile gets no loadRESULT. After acknowledge, that block is captured.
- Send 257 packets. countOUT reads 0..255, 0 in order, and err stays 0.
- Block with infoRES=8'h20. err rises and stays high, and the info byte has bit5=0. Assert nR low in WAIT2 or SEND: all outputs are 0 the next cycle and state is IDLE.
